// File: rtl/fs_accel_elw_pkg.sv
// Shared constants for the element-wise post-processing pipeline.
package fs_accel_elw_pkg;

  localparam logic [3:0] LAYER_CONV  = 4'd0;
  localparam logic [3:0] LAYER_DENSE = 4'd1;
  localparam logic [3:0] LAYER_MIXED = 4'd2;

  localparam logic [3:0] ACT_NONE = 4'd0;
  localparam logic [3:0] ACT_RELU = 4'd1;

  localparam int OUT_MIN = -128;
  localparam int OUT_MAX = 127;

  // Shift amounts above 31 behave as 31.
  function automatic logic [4:0] clamp_shift(input logic [7:0] rs);
    return (rs > 8'd31) ? 5'd31 : rs[4:0];
  endfunction

endpackage

// File: rtl/fs_accel_elw_lane.sv
// One lane of the element-wise pipeline: rounding high-multiply, rounding shift,
// activation, offset, saturation and the max-pool accumulator.
module fs_accel_elw_lane
  import fs_accel_elw_pkg::*;
#(
  parameter int DI_W = 32,
  parameter int DO_W = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clr,
  input  logic            p_en,
  input  logic            q2_en,
  input  logic            q3_en,
  input  logic            acc_en,
  input  logic            use_s3,
  input  logic            pool_merge,
  input  logic            act_relu,
  input  logic [31:0]     offset,
  input  logic [31:0]     muler,
  input  logic [7:0]      rshift,
  input  logic [DI_W-1:0] di,
  output logic [DO_W-1:0] res
);

  logic signed [63:0]     di_x;
  logic signed [63:0]     mu_x;
  logic signed [63:0]     p_q;
  logic signed [63:0]     h_wide;
  logic signed [31:0]     h;
  logic [4:0]             rs;
  logic signed [32:0]     h_ext;
  logic signed [32:0]     rnd;
  logic signed [32:0]     q_d;
  logic signed [32:0]     q2;
  logic signed [32:0]     q3;
  logic signed [32:0]     src;
  logic signed [32:0]     act;
  logic signed [33:0]     v_wide;
  logic signed [DO_W-1:0] v;
  logic signed [DO_W-1:0] acc_q;

  assign di_x = {{(64-DI_W){di[DI_W-1]}}, di};
  assign mu_x = {{32{muler[31]}}, muler};

  // NOTE: datapath registers carry no reset; the stage valid bits in the top decide
  // whether their contents mean anything, so clearing them would only add fan-out.
  always_ff @(posedge clk) begin
    if (p_en)  p_q <= di_x * mu_x;
    if (q2_en) q2  <= q_d;
    if (q3_en) q3  <= q2;
  end

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    h_wide = (p_q + 64'sd1073741824) >>> 31;
    if (h_wide > 64'sd2147483647)       h = 32'sh7fffffff;
    else if (h_wide < -64'sd2147483648) h = 32'sh80000000;
    else                                h = h_wide[31:0];

    rs    = clamp_shift(rshift);
    h_ext = {h[31], h};
    rnd   = '0;
    q_d   = h_ext;
    if (rs != 5'd0) begin
      rnd = 33'sd1 <<< (rs - 5'd1);
      q_d = (h_ext + rnd) >>> rs;
    end
  end

  // S3 reads the skid copy when it holds a beat, otherwise the S2 result directly.
  always_comb begin
    src    = use_s3 ? q3 : q2;
    act    = (act_relu && src[32]) ? '0 : src;
    v_wide = {act[32], act} - {{2{offset[31]}}, offset};
    if (v_wide > 34'(OUT_MAX))      v = DO_W'(OUT_MAX);
    else if (v_wide < 34'(OUT_MIN)) v = DO_W'(OUT_MIN);
    else                            v = v_wide[DO_W-1:0];
    res = (pool_merge && (acc_q > v)) ? acc_q : v;
  end

  always_ff @(posedge clk) begin
    if (!resetn || clr) acc_q <= '0;
    else if (acc_en)    acc_q <= res;
  end

endmodule

// File: rtl/fs_accel_elw_pipe.sv
// Valid/ready element-wise post-processing pipeline: NUM_CH requantising lanes,
// optional max-pool over a window of beats, and a registered output.
module fs_accel_elw_pipe
  import fs_accel_elw_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int DI_W     = 32,
  parameter int DO_W     = 8,
  parameter int POOL_MAX = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          clr,
  input  logic [3:0]                    cfg_layer_typ,
  input  logic [3:0]                    cfg_act_func_typ,
  input  logic [31:0]                   cfg_output_offset,
  input  logic [NUM_CH*32-1:0]          cfg_quant_muler,
  input  logic [NUM_CH*8-1:0]           cfg_quant_rshift,
  input  logic [$clog2(POOL_MAX+1)-1:0] cfg_pool_win,
  input  logic                          in_vld,
  output logic                          in_rdy,
  input  logic [NUM_CH*DI_W-1:0]        in_data,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [NUM_CH*DO_W-1:0]        out_data
);

  localparam int WIN_W = $clog2(POOL_MAX+1);

  logic                   s1_vld;
  logic                   s2_vld;
  logic                   s3_vld;
  logic                   accept;
  logic                   s1_adv;
  logic                   s2_adv;
  logic                   s2_to_s3;
  logic                   out_free;
  logic                   s3_take;
  logic                   last_beat;
  logic                   out_wr;
  logic                   pool_mode;
  logic                   pool_merge;
  logic                   act_relu;
  logic [WIN_W-1:0]       win_eff;
  logic [WIN_W-1:0]       cnt;
  logic [NUM_CH*DO_W-1:0] lane_res;

  always_comb begin
    pool_mode = 1'b0;
    act_relu  = 1'b0;
    case (cfg_layer_typ)
      LAYER_MIXED:             pool_mode = 1'b1;
      LAYER_CONV, LAYER_DENSE: pool_mode = 1'b0;
      default:                 pool_mode = 1'b0;
    endcase
    case (cfg_act_func_typ)
      ACT_RELU: act_relu = 1'b1;
      ACT_NONE: act_relu = 1'b0;
      default:  act_relu = 1'b0;
    endcase
    if (cfg_pool_win == '0)                  win_eff = WIN_W'(1);
    else if (cfg_pool_win > WIN_W'(POOL_MAX)) win_eff = WIN_W'(POOL_MAX);
    else                                     win_eff = cfg_pool_win;
  end

  // S3 is a one-entry skid: with the output free a beat passes straight from S2,
  // otherwise it parks in S3, giving four beats of storage at three cycles latency.
  assign out_free   = !out_vld || out_rdy;
  assign s3_take    = out_free && (s3_vld || s2_vld);
  assign s2_to_s3   = s2_vld && (s3_vld == out_free);
  assign s2_adv     = s2_vld && (out_free || !s3_vld);
  assign s1_adv     = s1_vld && (!s2_vld || s2_adv);
  assign in_rdy     = !s1_vld || s1_adv;
  assign accept     = in_vld && in_rdy;
  assign last_beat  = !pool_mode || (cnt == win_eff - WIN_W'(1));
  assign out_wr     = s3_take && last_beat;
  assign pool_merge = pool_mode && (cnt != '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      s3_vld   <= 1'b0;
      cnt      <= '0;
      out_vld  <= 1'b0;
      out_data <= '0;
    end else begin
      if (in_rdy)              s1_vld <= in_vld;
      if (!s2_vld || s2_adv)   s2_vld <= s1_vld;
      s3_vld <= s3_vld ? (!out_free || s2_vld) : (s2_vld && !out_free);
      if (s3_take && pool_mode) cnt <= last_beat ? '0 : cnt + WIN_W'(1);
      if (out_wr) begin
        out_vld  <= 1'b1;
        out_data <= lane_res;
      end else if (out_rdy) begin
        out_vld  <= 1'b0;
        out_data <= '0;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    fs_accel_elw_lane #(
      .DI_W(DI_W),
      .DO_W(DO_W)
    ) u_lane (
      .clk        (clk),
      .resetn     (resetn),
      .clr        (clr),
      .p_en       (accept),
      .q2_en      (s1_adv),
      .q3_en      (s2_to_s3),
      .acc_en     (s3_take),
      .use_s3     (s3_vld),
      .pool_merge (pool_merge),
      .act_relu   (act_relu),
      .offset     (cfg_output_offset),
      .muler      (cfg_quant_muler[32*i +: 32]),
      .rshift     (cfg_quant_rshift[8*i +: 8]),
      .di         (in_data[DI_W*i +: DI_W]),
      .res        (lane_res[DO_W*i +: DO_W])
    );
  end

endmodule

// File: tb/tb_fs_accel_elw_pipe.sv
// Directed bench for fs_accel_elw_pipe: requantisation, saturation, ReLU, pooling,
// backpressure and flush behaviour against hand-computed results.
module tb_fs_accel_elw_pipe;

  localparam int NUM_CH   = 3;
  localparam int DI_W     = 32;
  localparam int DO_W     = 8;
  localparam int POOL_MAX = 4;
  localparam int WIN_W    = $clog2(POOL_MAX+1);
  localparam logic [95:0] M1 = {3{32'h40000000}};

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   clr;
  logic [3:0]             cfg_layer_typ;
  logic [3:0]             cfg_act_func_typ;
  logic [31:0]            cfg_output_offset;
  logic [NUM_CH*32-1:0]   cfg_quant_muler;
  logic [NUM_CH*8-1:0]    cfg_quant_rshift;
  logic [WIN_W-1:0]       cfg_pool_win;
  logic                   in_vld;
  logic                   in_rdy;
  logic [NUM_CH*DI_W-1:0] in_data;
  logic                   out_vld;
  logic                   out_rdy;
  logic [NUM_CH*DO_W-1:0] out_data;

  int          tests = 0;
  int          fails = 0;
  logic [23:0] got[$];

  always #5 clk = ~clk;

  fs_accel_elw_pipe #(
    .NUM_CH(NUM_CH), .DI_W(DI_W), .DO_W(DO_W), .POOL_MAX(POOL_MAX)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .clr               (clr),
    .cfg_layer_typ     (cfg_layer_typ),
    .cfg_act_func_typ  (cfg_act_func_typ),
    .cfg_output_offset (cfg_output_offset),
    .cfg_quant_muler   (cfg_quant_muler),
    .cfg_quant_rshift  (cfg_quant_rshift),
    .cfg_pool_win      (cfg_pool_win),
    .in_vld            (in_vld),
    .in_rdy            (in_rdy),
    .in_data           (in_data),
    .out_vld           (out_vld),
    .out_rdy           (out_rdy),
    .out_data          (out_data)
  );

  // Record every delivered output beat (handshake completes at the next rising edge).
  always @(negedge clk) begin
    if (out_vld && out_rdy) got.push_back(out_data);
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [3:0] layer, input logic [3:0] act, input logic [31:0] off,
                         input logic [95:0] mul, input logic [23:0] rs, input logic [WIN_W-1:0] win);
    cfg_layer_typ     = layer;
    cfg_act_func_typ  = act;
    cfg_output_offset = off;
    cfg_quant_muler   = mul;
    cfg_quant_rshift  = rs;
    cfg_pool_win      = win;
  endtask

  task automatic send(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    int n;
    in_data = {d2, d1, d0};
    in_vld  = 1'b1;
    #1;
    n = 0;
    while (!in_rdy && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("send_in_rdy_timeout", in_rdy, 1);
    tick();
    in_vld = 1'b0;
  endtask

  task automatic send_all(input logic [31:0] d);
    send(d, d, d);
  endtask

  // One beat through an idle pipe: out_vld must rise exactly 3 cycles after acceptance.
  task automatic run1(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [23:0] exp, input string tag);
    send(d0, d1, d2);
    check({tag, "_vld_t1"}, out_vld, 0);
    tick();
    check({tag, "_vld_t2"}, out_vld, 0);
    tick();
    check({tag, "_vld_t3"}, out_vld, 1);
    check({tag, "_data"}, out_data, exp);
    tick();
    check({tag, "_vld_drop"}, out_vld, 0);
  endtask

  task automatic wait_got(input int n, input string tag);
    int c;
    c = 0;
    while (got.size() < n && c < 40) begin
      tick();
      c++;
    end
    repeat (6) tick();
    check(tag, got.size(), n);
  endtask

  task automatic send_pool_pattern();
    send_all(-32'sd10);
    send_all(32'sd14);
    send_all(32'sd6);
    send_all(-32'sd2);
  endtask

  initial begin
    int  k;
    int  c;
    logic rdy;

    resetn  = 1'b0;
    clr     = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    out_rdy = 1'b1;
    set_cfg(4'd0, 4'd0, 32'd0, M1, 24'd0, 3'd4);
    repeat (3) tick();
    check("reset_in_rdy", in_rdy, 1);
    check("reset_out_vld", out_vld, 0);
    check("reset_out_data", out_data, 0);
    resetn = 1'b1;
    tick();

    // Requantisation and saturation
    set_cfg(4'd0, 4'd0, -32'sd3, M1, {3{8'd2}}, 3'd4);
    run1(32'd1000, 32'd1000, 32'd1000, 24'h7F7F7F, "requant_sat");
    set_cfg(4'd0, 4'd0, 32'd0, M1, {3{8'd2}}, 3'd4);
    run1(32'd1000, 32'd4, -32'sd1000, 24'h83017D, "requant");
    set_cfg(4'd0, 4'd0, 32'd0, {3{32'h80000000}}, 24'd0, 3'd4);
    run1(32'h80000000, 32'h80000000, 32'h80000000, 24'h7F7F7F, "ovf_corner");
    set_cfg(4'd0, 4'd0, 32'd0, M1, 24'd0, 3'd4);
    run1(-32'sd1000, 32'd0, 32'd254, 24'h7F0080, "neg_sat");
    set_cfg(4'd0, 4'd0, 32'd0, {3{32'h7FFFFFFF}}, {8'd255, 8'd32, 8'd31}, 3'd4);
    run1(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 24'h010101, "rs_clamp");
    set_cfg(4'd0, 4'd0, 32'd0, M1, {8'd2, 8'd1, 8'd0}, 3'd4);
    run1(32'd100, 32'd100, 32'd100, 24'h0D1932, "lane_rs");

    // Activation
    set_cfg(4'd0, 4'd1, 32'd5, M1, 24'd0, 3'd4);
    run1(32'd40, -32'sd400, 32'd100, 24'h2DFB0F, "relu");
    set_cfg(4'd1, 4'd3, 32'd5, M1, 24'd0, 3'd4);
    run1(-32'sd400, -32'sd400, 32'd40, 24'h0F8080, "act_other");

    // Pooling, window 4: lanes see (-5,7,3,-1), (7,-5,-1,3), (-1,-1,-1,-1)
    set_cfg(4'd2, 4'd0, 32'd0, M1, 24'd0, 3'd4);
    got.delete();
    send(-32'sd10, 32'sd14, -32'sd2);
    send(32'sd14, -32'sd10, -32'sd2);
    send(32'sd6, -32'sd2, -32'sd2);
    send(-32'sd2, 32'sd6, -32'sd2);
    check("pool_no_partial", out_vld, 0);
    tick();
    check("pool_vld_t2", out_vld, 0);
    tick();
    check("pool_vld_t3", out_vld, 1);
    check("pool_data", out_data, 24'hFF0707);
    send_all(32'sd0);
    send_all(-32'sd20);
    send_all(32'sd8);
    send_all(32'sd2);
    wait_got(2, "pool_count");
    if (got.size() >= 2) check("pool_second", got[1], 24'h040404);

    // Window 0 behaves as 1, window 7 behaves as POOL_MAX
    set_cfg(4'd2, 4'd0, 32'd0, M1, 24'd0, 3'd0);
    got.delete();
    send_all(32'sd14);
    send_all(32'sd6);
    wait_got(2, "win0_count");
    if (got.size() >= 2) begin
      check("win0_first", got[0], 24'h070707);
      check("win0_second", got[1], 24'h030303);
    end
    set_cfg(4'd2, 4'd0, 32'd0, M1, 24'd0, 3'd7);
    got.delete();
    send_pool_pattern();
    wait_got(1, "win_clamp_count");
    if (got.size() >= 1) check("win_clamp_data", got[0], 24'h070707);

    // clr mid-window discards the partial window
    set_cfg(4'd2, 4'd0, 32'd0, M1, 24'd0, 3'd4);
    got.delete();
    send_all(32'sd200);
    send_all(32'sd200);
    repeat (4) tick();
    check("clr_partial_vld", out_vld, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    send_pool_pattern();
    wait_got(1, "clr_count");
    if (got.size() >= 1) check("clr_data", got[0], 24'h070707);

    // resetn mid-window
    got.delete();
    send_all(32'sd200);
    send_all(32'sd200);
    repeat (4) tick();
    resetn = 1'b0;
    tick();
    check("rst_out_vld", out_vld, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_rdy", in_rdy, 1);
    resetn = 1'b1;
    send_pool_pattern();
    wait_got(1, "rst_count");
    if (got.size() >= 1) check("rst_data", got[0], 24'h070707);

    // clr empties a held output register
    set_cfg(4'd0, 4'd0, 32'd0, M1, 24'd0, 3'd4);
    out_rdy = 1'b0;
    send_all(32'd1000);
    tick();
    tick();
    check("clr_out_held", out_vld, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_out_vld", out_vld, 0);
    check("clr_out_data", out_data, 0);
    out_rdy = 1'b1;
    tick();

    // Backpressure: beat k carries di = 2k+2, which requantises to k+1
    got.delete();
    out_rdy = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_vld  = (k < 6);
      in_data = {3{32'(2*k+2)}};
      #1;
      rdy = in_rdy;
      tick();
      if (rdy) k++;
      if (cyc >= 2) begin
        check("bp_hold_vld", out_vld, 1);
        check("bp_hold_data", out_data, 24'h010101);
      end
    end
    check("bp_accepted", k, 4);
    check("bp_in_rdy_low", in_rdy, 0);
    out_rdy = 1'b1;
    c = 0;
    while (k < 6 && c < 20) begin
      in_vld  = 1'b1;
      in_data = {3{32'(2*k+2)}};
      #1;
      rdy = in_rdy;
      tick();
      if (rdy) k++;
      c++;
    end
    in_vld = 1'b0;
    wait_got(6, "bp_count");
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) check("bp_order", got[i], {3{8'(i+1)}});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
